// File: rtl/dmi_arbiter.sv
// Two-master DMI arbiter: one outstanding transaction, responses routed back to the issuing master.
// NOP and reserved ops are answered locally without touching the debug module.
module dmi_arbiter #(
    parameter bit FixedPrio = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [1:0][40:0] m_req_i,
    input  logic [1:0]       m_req_valid_i,
    output logic [1:0]       m_req_ready_o,
    output logic [1:0][33:0] m_resp_o,
    output logic [1:0]       m_resp_valid_o,
    input  logic [1:0]       m_resp_ready_i,
    output logic [40:0]      dmi_req_o,
    output logic             dmi_req_valid_o,
    input  logic             dmi_req_ready_i,
    input  logic [33:0]      dmi_resp_i,
    input  logic             dmi_resp_valid_i,
    output logic             dmi_resp_ready_o,
    output logic             gnt_o,
    output logic             busy_o
);

    typedef enum logic [1:0] {Idle, Issue, WaitResp, LocalResp} state_e;

    localparam logic [1:0] DtmNop     = 2'd0;
    localparam logic [1:0] DtmRead    = 2'd1;
    localparam logic [1:0] DtmWrite   = 2'd2;
    localparam logic [1:0] DtmSuccess = 2'd0;
    localparam logic [1:0] DtmErr     = 2'd2;

    state_e      state_q;
    logic        gnt_q;
    logic        prio_q;
    logic [40:0] req_q;
    logic [33:0] resp_q;

    logic        winner;
    logic [40:0] win_req;
    logic [1:0]  win_op;

    // prio_q only breaks ties; a lone valid port always wins
    always_comb begin
        winner = 1'b0;
        if (m_req_valid_i == 2'b11) begin
            winner = FixedPrio ? 1'b0 : prio_q;
        end else if (m_req_valid_i[1]) begin
            winner = 1'b1;
        end
    end

    assign win_req = m_req_i[winner];
    assign win_op  = win_req[1:0];

    always_comb begin
        m_req_ready_o    = '0;
        m_resp_valid_o   = '0;
        m_resp_o         = '0;
        dmi_resp_ready_o = 1'b0;
        case (state_q)
            Idle: begin
                if (|m_req_valid_i) begin
                    m_req_ready_o[winner] = 1'b1;
                end
            end
            WaitResp: begin
                m_resp_valid_o[gnt_q] = dmi_resp_valid_i;
                m_resp_o[gnt_q]       = dmi_resp_i;
                dmi_resp_ready_o      = m_resp_ready_i[gnt_q];
            end
            LocalResp: begin
                m_resp_valid_o[gnt_q] = 1'b1;
                m_resp_o[gnt_q]       = resp_q;
            end
            default: begin
            end
        endcase
    end

    assign dmi_req_valid_o = (state_q == Issue);
    assign dmi_req_o       = req_q;
    assign gnt_o           = gnt_q;
    assign busy_o          = (state_q != Idle);

    // Stray downstream responses outside WaitResp never advance the FSM
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= Idle;
            gnt_q   <= 1'b0;
            prio_q  <= 1'b0;
            req_q   <= '0;
            resp_q  <= '0;
        end else begin
            case (state_q)
                Idle: begin
                    if (|m_req_valid_i) begin
                        req_q <= win_req;
                        gnt_q <= winner;
                        if (win_op == DtmRead || win_op == DtmWrite) begin
                            state_q <= Issue;
                        end else begin
                            resp_q  <= {32'h0, (win_op == DtmNop) ? DtmSuccess : DtmErr};
                            state_q <= LocalResp;
                        end
                    end
                end
                Issue: begin
                    if (dmi_req_ready_i) begin
                        state_q <= WaitResp;
                    end
                end
                WaitResp: begin
                    if (dmi_resp_valid_i && m_resp_ready_i[gnt_q]) begin
                        state_q <= Idle;
                        if (!FixedPrio) begin
                            prio_q <= ~gnt_q;
                        end
                    end
                end
                LocalResp: begin
                    if (m_resp_ready_i[gnt_q]) begin
                        state_q <= Idle;
                        if (!FixedPrio) begin
                            prio_q <= ~gnt_q;
                        end
                    end
                end
                default: begin
                    state_q <= Idle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmi_arbiter.sv
// Directed testbench for dmi_arbiter: a round-robin instance plus a fixed-priority instance.
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
module tb_dmi_arbiter;

    localparam logic [1:0] OpNop   = 2'd0;
    localparam logic [1:0] OpRead  = 2'd1;
    localparam logic [1:0] OpWrite = 2'd2;
    localparam logic [1:0] OpRsvd  = 2'd3;

    logic             clk_i = 1'b0;
    logic             rst_ni = 1'b0;
    logic [1:0][40:0] m_req_i;
    logic [1:0]       m_req_valid_i;
    logic [1:0]       m_req_ready_o;
    logic [1:0][33:0] m_resp_o;
    logic [1:0]       m_resp_valid_o;
    logic [1:0]       m_resp_ready_i;
    logic [40:0]      dmi_req_o;
    logic             dmi_req_valid_o;
    logic             dmi_req_ready_i;
    logic [33:0]      dmi_resp_i;
    logic             dmi_resp_valid_i;
    logic             dmi_resp_ready_o;
    logic             gnt_o;
    logic             busy_o;

    logic [1:0][40:0] fp_req;
    logic [1:0]       fp_req_valid;
    logic [1:0]       fp_req_ready;
    logic [1:0][33:0] fp_resp;
    logic [1:0]       fp_resp_valid;
    logic [1:0]       fp_resp_ready;
    logic [40:0]      fp_dmi_req;
    logic             fp_dmi_req_valid;
    logic             fp_dmi_resp_ready;
    logic             fp_gnt;
    logic             fp_busy;

    int compared = 0;
    int mismatched = 0;

    always #5 clk_i = ~clk_i;

    dmi_arbiter #(.FixedPrio(1'b0)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .m_req_i(m_req_i), .m_req_valid_i(m_req_valid_i), .m_req_ready_o(m_req_ready_o),
        .m_resp_o(m_resp_o), .m_resp_valid_o(m_resp_valid_o), .m_resp_ready_i(m_resp_ready_i),
        .dmi_req_o(dmi_req_o), .dmi_req_valid_o(dmi_req_valid_o), .dmi_req_ready_i(dmi_req_ready_i),
        .dmi_resp_i(dmi_resp_i), .dmi_resp_valid_i(dmi_resp_valid_i), .dmi_resp_ready_o(dmi_resp_ready_o),
        .gnt_o(gnt_o), .busy_o(busy_o)
    );

    dmi_arbiter #(.FixedPrio(1'b1)) dut_fp (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .m_req_i(fp_req), .m_req_valid_i(fp_req_valid), .m_req_ready_o(fp_req_ready),
        .m_resp_o(fp_resp), .m_resp_valid_o(fp_resp_valid), .m_resp_ready_i(fp_resp_ready),
        .dmi_req_o(fp_dmi_req), .dmi_req_valid_o(fp_dmi_req_valid), .dmi_req_ready_i(dmi_req_ready_i),
        .dmi_resp_i(dmi_resp_i), .dmi_resp_valid_i(dmi_resp_valid_i), .dmi_resp_ready_o(fp_dmi_resp_ready),
        .gnt_o(fp_gnt), .busy_o(fp_busy)
    );

    function automatic logic [40:0] mkReq(input logic [6:0] addr, input logic [31:0] data,
                                          input logic [1:0] op);
        return {addr, data, op};
    endfunction

    function automatic logic [33:0] mkResp(input logic [31:0] data, input logic [1:0] resp);
        return {data, resp};
    endfunction

    task automatic applyStimulus(input logic [40:0] req0, input logic [40:0] req1,
                                 input logic [1:0] valid, input logic [1:0] resp_ready);
        m_req_i[0]     = req0;
        m_req_i[1]     = req1;
        m_req_valid_i  = valid;
        m_resp_ready_i = resp_ready;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        @(negedge clk_i);
    endtask

    task automatic doReset();
        nextCycle();
        rst_ni = 1'b0;
        applyStimulus('0, '0, 2'b00, 2'b00);
        dmi_req_ready_i  = 1'b0;
        dmi_resp_valid_i = 1'b0;
        dmi_resp_i       = '0;
        nextCycle();
        nextCycle();
        rst_ni = 1'b1;
    endtask

    initial begin
        applyStimulus('0, '0, 2'b00, 2'b00);
        fp_req           = '0;
        fp_req_valid     = 2'b00;
        fp_resp_ready    = 2'b00;
        dmi_req_ready_i  = 1'b0;
        dmi_resp_valid_i = 1'b0;
        dmi_resp_i       = '0;

        // Reset values
        settle();
        checkOutput("rst_busy", busy_o, 0);
        checkOutput("rst_gnt", gnt_o, 0);
        checkOutput("rst_req_valid", dmi_req_valid_o, 0);
        checkOutput("rst_req", dmi_req_o, 0);
        checkOutput("rst_resp_valid", m_resp_valid_o, 0);
        checkOutput("rst_resp", m_resp_o, 0);
        checkOutput("rst_dmi_resp_ready", dmi_resp_ready_o, 0);
        nextCycle();
        rst_ni = 1'b1;

        // Single read on port 0
        nextCycle();
        applyStimulus(mkReq(7'h11, 32'h0, OpRead), '0, 2'b01, 2'b11);
        settle();
        checkOutput("rd_accept_ready", m_req_ready_o, 2'b01);
        checkOutput("rd_accept_req_valid", dmi_req_valid_o, 0);
        nextCycle();
        applyStimulus('0, '0, 2'b00, 2'b11);
        dmi_req_ready_i = 1'b1;
        settle();
        checkOutput("rd_issue_valid", dmi_req_valid_o, 1);
        checkOutput("rd_issue_addr", dmi_req_o[40:34], 7'h11);
        checkOutput("rd_issue_busy", busy_o, 1);
        nextCycle();
        dmi_req_ready_i  = 1'b0;
        dmi_resp_i       = mkResp(32'hDEADBEEF, 2'd0);
        dmi_resp_valid_i = 1'b1;
        settle();
        checkOutput("rd_resp_valid", m_resp_valid_o, 2'b01);
        checkOutput("rd_resp0", m_resp_o[0], 34'h3_7AB6_FBBC);
        checkOutput("rd_resp1_silent", m_resp_o[1], 0);
        checkOutput("rd_dmi_resp_ready", dmi_resp_ready_o, 1);
        nextCycle();
        dmi_resp_valid_i = 1'b0;
        settle();
        checkOutput("rd_done_busy", busy_o, 0);

        // Tie from reset: port 0 first, then port 1 wins the next tie
        doReset();
        nextCycle();
        applyStimulus(mkReq(7'h01, 32'h0, OpRead), mkReq(7'h02, 32'h0, OpRead), 2'b11, 2'b11);
        settle();
        checkOutput("tie1_ready", m_req_ready_o, 2'b01);
        nextCycle();
        applyStimulus('0, mkReq(7'h02, 32'h0, OpRead), 2'b10, 2'b11);
        dmi_req_ready_i = 1'b1;
        settle();
        checkOutput("tie1_issue_addr", dmi_req_o[40:34], 7'h01);
        checkOutput("tie1_loser_waits", m_req_ready_o, 2'b00);
        nextCycle();
        dmi_req_ready_i  = 1'b0;
        dmi_resp_i       = mkResp(32'h100, 2'd0);
        dmi_resp_valid_i = 1'b1;
        settle();
        checkOutput("tie1_resp_valid", m_resp_valid_o, 2'b01);
        nextCycle();
        dmi_resp_valid_i = 1'b0;
        applyStimulus(mkReq(7'h03, 32'h0, OpRead), mkReq(7'h02, 32'h0, OpRead), 2'b11, 2'b11);
        settle();
        checkOutput("tie2_ready", m_req_ready_o, 2'b10);
        nextCycle();
        applyStimulus(mkReq(7'h03, 32'h0, OpRead), '0, 2'b01, 2'b11);
        dmi_req_ready_i = 1'b1;
        settle();
        checkOutput("tie2_gnt", gnt_o, 1);
        checkOutput("tie2_issue_addr", dmi_req_o[40:34], 7'h02);
        nextCycle();
        dmi_req_ready_i  = 1'b0;
        dmi_resp_i       = mkResp(32'h200, 2'd0);
        dmi_resp_valid_i = 1'b1;
        settle();
        checkOutput("tie2_resp_valid", m_resp_valid_o, 2'b10);
        checkOutput("tie2_resp1", m_resp_o[1], 34'h800);
        checkOutput("tie2_resp0_zero", m_resp_o[0], 0);
        checkOutput("hs_ignores_new_valid", m_req_ready_o, 2'b00);
        nextCycle();
        dmi_resp_valid_i = 1'b0;
        settle();
        checkOutput("pending_accepted_next", m_req_ready_o, 2'b01);

        // Fixed priority: port 0 wins both ties
        doReset();
        nextCycle();
        fp_req[0]     = mkReq(7'h04, 32'h0, OpNop);
        fp_req[1]     = mkReq(7'h05, 32'h0, OpNop);
        fp_req_valid  = 2'b11;
        fp_resp_ready = 2'b11;
        settle();
        checkOutput("fp_tie1_ready", fp_req_ready, 2'b01);
        nextCycle();
        settle();
        checkOutput("fp_local_resp_valid", fp_resp_valid, 2'b01);
        checkOutput("fp_no_downstream", fp_dmi_req_valid, 0);
        nextCycle();
        settle();
        checkOutput("fp_tie2_ready", fp_req_ready, 2'b01);
        nextCycle();
        fp_req_valid = 2'b00;
        nextCycle();
        settle();
        checkOutput("fp_idle", fp_busy, 0);

        // Backpressure on port 1
        doReset();
        nextCycle();
        applyStimulus('0, mkReq(7'h22, 32'hCAFEF00D, OpWrite), 2'b10, 2'b00);
        settle();
        checkOutput("bp_accept", m_req_ready_o, 2'b10);
        for (int i = 0; i < 5; i++) begin
            nextCycle();
            applyStimulus('0, '0, 2'b00, 2'b00);
            settle();
            checkOutput("bp_req_valid_held", dmi_req_valid_o, 1);
            checkOutput("bp_req_stable", dmi_req_o, {7'h22, 32'hCAFEF00D, 2'd2});
        end
        nextCycle();
        dmi_req_ready_i = 1'b1;
        settle();
        checkOutput("bp_req_valid_at_ready", dmi_req_valid_o, 1);
        nextCycle();
        dmi_req_ready_i  = 1'b0;
        dmi_resp_i       = mkResp(32'h1234, 2'd0);
        dmi_resp_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            checkOutput("bp_resp_ready_low", dmi_resp_ready_o, 0);
            checkOutput("bp_resp_valid_held", m_resp_valid_o, 2'b10);
            nextCycle();
        end
        m_resp_ready_i = 2'b10;
        settle();
        checkOutput("bp_resp_ready_high", dmi_resp_ready_o, 1);
        checkOutput("bp_resp_data", m_resp_o[1], 34'h48D0);
        nextCycle();
        dmi_resp_valid_i = 1'b0;
        settle();
        checkOutput("bp_done_busy", busy_o, 0);

        // NOP then reserved op on port 1, answered locally
        nextCycle();
        applyStimulus('0, mkReq(7'h05, 32'h0, OpNop), 2'b10, 2'b10);
        settle();
        checkOutput("nop_accept", m_req_ready_o, 2'b10);
        nextCycle();
        applyStimulus('0, '0, 2'b00, 2'b10);
        settle();
        checkOutput("nop_resp_valid", m_resp_valid_o, 2'b10);
        checkOutput("nop_resp", m_resp_o[1], 34'h0);
        checkOutput("nop_no_downstream", dmi_req_valid_o, 0);
        nextCycle();
        applyStimulus('0, mkReq(7'h05, 32'h0, OpRsvd), 2'b10, 2'b10);
        settle();
        checkOutput("rsvd_accept", m_req_ready_o, 2'b10);
        nextCycle();
        applyStimulus('0, '0, 2'b00, 2'b10);
        settle();
        checkOutput("rsvd_resp_valid", m_resp_valid_o, 2'b10);
        checkOutput("rsvd_resp", m_resp_o[1], 34'h2);
        checkOutput("rsvd_no_downstream", dmi_req_valid_o, 0);
        nextCycle();

        // Stray downstream response while idle is ignored
        dmi_resp_valid_i = 1'b1;
        settle();
        checkOutput("stray_resp_ready", dmi_resp_ready_o, 0);
        checkOutput("stray_resp_valid", m_resp_valid_o, 2'b00);
        nextCycle();
        dmi_resp_valid_i = 1'b0;

        // Asynchronous reset during WaitResp
        applyStimulus('0, mkReq(7'h03, 32'h0, OpRead), 2'b10, 2'b10);
        nextCycle();
        applyStimulus('0, '0, 2'b00, 2'b10);
        dmi_req_ready_i = 1'b1;
        nextCycle();
        dmi_req_ready_i = 1'b0;
        settle();
        checkOutput("wr_pre_busy", busy_o, 1);
        checkOutput("wr_pre_resp_ready", dmi_resp_ready_o, 1);
        rst_ni = 1'b0;
        #1;
        checkOutput("arst_busy", busy_o, 0);
        checkOutput("arst_gnt", gnt_o, 0);
        checkOutput("arst_resp_ready", dmi_resp_ready_o, 0);
        checkOutput("arst_req", dmi_req_o, 0);
        checkOutput("arst_req_valid", dmi_req_valid_o, 0);
        nextCycle();
        rst_ni = 1'b1;
        nextCycle();
        applyStimulus('0, mkReq(7'h10, 32'h1, OpWrite), 2'b10, 2'b10);
        settle();
        checkOutput("post_accept", m_req_ready_o, 2'b10);
        nextCycle();
        applyStimulus('0, '0, 2'b00, 2'b10);
        dmi_req_ready_i = 1'b1;
        settle();
        checkOutput("post_issue_req", dmi_req_o, {7'h10, 32'h1, 2'd2});
        nextCycle();
        dmi_req_ready_i  = 1'b0;
        dmi_resp_i       = mkResp(32'h0, 2'd0);
        dmi_resp_valid_i = 1'b1;
        settle();
        checkOutput("post_resp_valid", m_resp_valid_o, 2'b10);
        nextCycle();
        dmi_resp_valid_i = 1'b0;
        settle();
        checkOutput("post_done_busy", busy_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
